syn_weight_mem: RTL and testbench

//  Parametrised synapse-weight store for the SNN core: N_NUM neurons x G_NUM groups of DW-bit weights.

---
 rtl/syn_weight_mem.sv | 233 +++++++++++++++++++++++
 tb/tb_syn_weight_mem.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_weight_mem.sv
// -----------------------------------------------------------------------------
// syn_weight_mem
//   Synapse-weight store for the SNN core: N_NUM neurons x G_NUM groups of
//   DW-bit weights. The weight-load path writes words; the SYN_ACCU stage reads
//   single words or all G_NUM groups of one neuron as a burst.
//
//   After reset, and on clr_start, a sweep writes zero to every word (one word
//   per cycle). Writes are row-remapped (stored row = N_NUM-1-neuron) to match
//   the weight-load ordering; reads use the address as given.
//
//   Read pipeline: the array is read at the edge that accepts a request (or
//   issues a burst beat) into a p0 register, then moved to dout on the next
//   edge, so a result is visible one cycle after acceptance.
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous reset, active-low
//   wr_en      in   write strobe
//   wr_addr    in   {neuron, group} write address
//   wr_data    in   write data
//   rd_req     in   read request, taken when neither a burst nor a clear runs
//   rd_burst   in   with rd_req: read all groups of rd_addr's neuron
//   rd_addr    in   {neuron, group} read address
//   clr_start  in   start a clear sweep
//   dout       out  read data, 0 whenever dout_valid=0
//   dout_valid out  dout holds a read result this cycle
//   dout_last  out  final beat of a single read or burst
//   rd_busy    out  burst in progress
//   clr_busy   out  clear sweep in progress
//
// Configuration
//   SYN_WR_BYPASS_EN : when defined, a write landing on the word read in the
//   same cycle is forwarded to the read result. When undefined the read
//   returns the word's previous contents.
// -----------------------------------------------------------------------------
module syn_weight_mem #(
    parameter int N_NUM = 32,
    parameter int G_NUM = 4,
    parameter int DW    = 32,
    parameter int N_SZ  = (N_NUM > 1) ? $clog2(N_NUM) : 1,
    parameter int G_SZ  = (G_NUM > 1) ? $clog2(G_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [N_SZ+G_SZ-1:0] wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 rd_req,
    input  logic                 rd_burst,
    input  logic [N_SZ+G_SZ-1:0] rd_addr,
    input  logic                 clr_start,
    output logic [DW-1:0]        dout,
    output logic                 dout_valid,
    output logic                 dout_last,
    output logic                 rd_busy,
    output logic                 clr_busy
);

    localparam int AW  = N_SZ + G_SZ;
    localparam int TOT = N_NUM * G_NUM;
    localparam int IW  = (TOT > 1) ? $clog2(TOT) : 1;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    function automatic logic in_range(input logic [N_SZ-1:0] n, input logic [G_SZ-1:0] g);
        return (int'(n) < N_NUM) && (int'(g) < G_NUM);
    endfunction

    function automatic logic [IW-1:0] phys_idx(input logic [N_SZ-1:0] n, input logic [G_SZ-1:0] g);
        return IW'(int'(n) * G_NUM + int'(g));
    endfunction

    logic [DW-1:0] mem [TOT];

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [G_SZ-1:0] beat_q, beat_d;
    logic [N_SZ-1:0] bn_q, bn_d;

    logic            vld_p0_q, last_p0_q, brst_p0_q;
    logic [DW-1:0]   data_p0_q;
    logic [DW-1:0]   dout_q;
    logic            dout_valid_q, dout_last_q;

    logic [N_SZ-1:0] wr_n, rd_an, rd_n;
    logic [G_SZ-1:0] wr_g, rd_ag, rd_g;
    logic [N_SZ-1:0] wr_row;
    logic            wr_ok, rd_fire, rd_last, rd_brst, rd_ok;
    logic [IW-1:0]   wr_idx, rd_idx;
    logic            mem_we;
    logic [IW-1:0]   mem_widx;
    logic [DW-1:0]   mem_wdat;
    logic [DW-1:0]   rd_word;

    assign wr_n  = wr_addr[AW-1:G_SZ];
    assign wr_g  = wr_addr[G_SZ-1:0];
    assign rd_an = rd_addr[AW-1:G_SZ];
    assign rd_ag = rd_addr[G_SZ-1:0];

    // The last burst beat still sits in p0 for one cycle after the FSM has
    // returned to IDLE; busy covers it so no request slips in before dout_last.
    assign rd_busy  = (state_q == ST_BURST) | brst_p0_q;
    assign clr_busy = (state_q == ST_CLEAR);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        beat_d    = beat_q;
        bn_d      = bn_q;
        rd_fire   = 1'b0;
        rd_n      = '0;
        rd_g      = '0;
        rd_last   = 1'b0;
        rd_brst   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + IW'(1);
                if (clr_cnt_q == IW'(TOT - 1)) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end
            end
            ST_IDLE: begin
                if (!rd_busy) begin
                    if (clr_start) begin
                        state_d   = ST_CLEAR;
                        clr_cnt_d = '0;
                    end else if (rd_req) begin
                        rd_fire = 1'b1;
                        rd_n    = rd_an;
                        if (rd_burst) begin
                            rd_g    = '0;
                            rd_brst = 1'b1;
                            rd_last = (G_NUM == 1);
                            if (G_NUM > 1) begin
                                state_d = ST_BURST;
                                beat_d  = G_SZ'(1);
                                bn_d    = rd_an;
                            end
                        end else begin
                            rd_g    = rd_ag;
                            rd_last = 1'b1;
                        end
                    end
                end
            end
            ST_BURST: begin
                rd_fire = 1'b1;
                rd_n    = bn_q;
                rd_g    = beat_q;
                rd_brst = 1'b1;
                rd_last = (beat_q == G_SZ'(G_NUM - 1));
                beat_d  = beat_q + G_SZ'(1);
                if (rd_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Write port: the clear sweep owns the array; otherwise remapped user writes.
    assign wr_row   = N_SZ'(N_NUM - 1) - wr_n;
    assign wr_ok    = (state_q != ST_CLEAR) && wr_en && in_range(wr_n, wr_g);
    assign wr_idx   = phys_idx(wr_row, wr_g);
    assign mem_we   = rst && ((state_q == ST_CLEAR) || wr_ok);
    assign mem_widx = (state_q == ST_CLEAR) ? clr_cnt_q : wr_idx;
    assign mem_wdat = (state_q == ST_CLEAR) ? '0 : wr_data;

    assign rd_ok  = in_range(rd_n, rd_g);
    assign rd_idx = phys_idx(rd_n, rd_g);

    // Out-of-range beats still complete, carrying zero data.
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[rd_idx];
`ifdef SYN_WR_BYPASS_EN
            if (wr_ok && (wr_idx == rd_idx)) begin
                rd_word = wr_data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    // Stage p0: array read at acceptance / beat issue
    always_ff @(posedge clk) begin
        data_p0_q <= rd_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            beat_q       <= '0;
            bn_q         <= '0;
            vld_p0_q     <= 1'b0;
            last_p0_q    <= 1'b0;
            brst_p0_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            beat_q       <= beat_d;
            bn_q         <= bn_d;
            vld_p0_q     <= rd_fire;
            last_p0_q    <= rd_fire & rd_last;
            brst_p0_q    <= rd_fire & rd_brst;
            // Stage p1: output register
            dout_q       <= vld_p0_q ? data_p0_q : '0;
            dout_valid_q <= vld_p0_q;
            dout_last_q  <= last_p0_q;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_syn_weight_mem.sv
module tb_syn_weight_mem;

    localparam int N_NUM = 32;
    localparam int G_NUM = 4;
    localparam int DW    = 32;
    localparam int N_SZ  = 5;
    localparam int G_SZ  = 2;
    localparam int AW    = N_SZ + G_SZ;
    localparam int TOT   = N_NUM * G_NUM;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic          rd_burst = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          clr_start = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_last;
    logic          rd_busy;
    logic          clr_busy;

    always #5 clk = ~clk;

    syn_weight_mem #(.N_NUM(N_NUM), .G_NUM(G_NUM), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_burst(rd_burst), .rd_addr(rd_addr),
        .clr_start(clr_start),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
        .rd_busy(rd_busy), .clr_busy(clr_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: word array indexed by physical row*G_NUM+group, a count
    // of remaining clear cycles, remaining burst beats, and a two-deep delay
    // line (issued beat -> visible beat) for the one-cycle read latency.
    logic [DW-1:0] m_mem [TOT];
    int            clr_left;
    int            burst_left;
    int            burst_n;
    bit            p0_v, p0_l, p0_b;
    logic [DW-1:0] p0_d;
    bit            o_v, o_l;
    logic [DW-1:0] o_d;

    function automatic logic [AW-1:0] adr(input int n, input int g);
        logic [N_SZ-1:0] nn;
        logic [G_SZ-1:0] gg;
        nn = N_SZ'(n);
        gg = G_SZ'(g);
        return {nn, gg};
    endfunction

    task automatic m_reset();
        clr_left   = TOT;
        burst_left = 0;
        burst_n    = 0;
        p0_v = 0; p0_l = 0; p0_b = 0; p0_d = '0;
        o_v = 0; o_l = 0; o_d = '0;
        for (int i = 0; i < TOT; i++) m_mem[i] = '0;
    endtask

    function automatic logic [DW-1:0] beat_value(input int n, input int g, input bit wok, input int wphys);
        logic [DW-1:0] v;
        int            phys;
        if (n >= N_NUM || g >= G_NUM) return '0;
        phys = n * G_NUM + g;
        v = m_mem[phys];
`ifdef SYN_WR_BYPASS_EN
        if (wok && wphys == phys) v = wr_data;
`endif
        return v;
    endfunction

    task automatic model_edge();
        bit            nv, nl, nb, wok, busy, clr_go;
        logic [DW-1:0] nd;
        int            wn, wg, wphys, rn, rg;
        o_v = p0_v;
        o_l = p0_l;
        o_d = p0_v ? p0_d : '0;
        nv = 0; nl = 0; nb = 0; nd = '0; wok = 0; clr_go = 0;
        rn = 0; rg = 0;
        wn = int'(wr_addr[AW-1:G_SZ]);
        wg = int'(wr_addr[G_SZ-1:0]);
        wphys = (N_NUM - 1 - wn) * G_NUM + wg;
        if (clr_left > 0) begin
            clr_left--;
        end else begin
            busy = (burst_left > 0) || p0_b;
            wok  = wr_en && (wn < N_NUM) && (wg < G_NUM);
            if (burst_left > 0) begin
                rn = burst_n;
                rg = G_NUM - burst_left;
                nv = 1; nb = 1;
                nl = (burst_left == 1);
                burst_left--;
            end else if (!busy && clr_start) begin
                clr_go = 1;
            end else if (!busy && rd_req) begin
                rn = int'(rd_addr[AW-1:G_SZ]);
                nv = 1;
                if (rd_burst) begin
                    rg = 0; nb = 1;
                    burst_left = G_NUM - 1;
                    burst_n = rn;
                    nl = (G_NUM == 1);
                end else begin
                    rg = int'(rd_addr[G_SZ-1:0]);
                    nl = 1;
                end
            end
            if (nv) nd = beat_value(rn, rg, wok, wphys);
            if (wok) m_mem[wphys] = wr_data;
            if (clr_go) begin
                clr_left = TOT;
                for (int i = 0; i < TOT; i++) m_mem[i] = '0;
            end
        end
        p0_v = nv; p0_l = nl; p0_b = nb; p0_d = nd;
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge,
    // then strobes return to idle for the next cycle's driver.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("dout",       dout, o_d);
        chk("dout_valid", 32'(dout_valid), 32'(o_v));
        chk("dout_last",  32'(dout_last), 32'(o_l));
        chk("rd_busy",    32'(rd_busy), 32'((burst_left > 0) || p0_b));
        chk("clr_busy",   32'(clr_busy), 32'(clr_left > 0));
        wr_en = 0; rd_req = 0; rd_burst = 0; clr_start = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            cnt;
        int            nbeats;
        int            nlast;
        logic [DW-1:0] beats [8];
        logic [DW-1:0] exp4;

        m_reset();
        #7;
        chk("rst_dout",       dout, '0);
        chk("rst_dout_valid", 32'(dout_valid), 0);
        chk("rst_dout_last",  32'(dout_last), 0);
        chk("rst_rd_busy",    32'(rd_busy), 0);
        chk("rst_clr_busy",   32'(clr_busy), 1);
        @(negedge clk);
        rst = 1;

        // Test 1: initial sweep length, then reads of first and last word
        cnt = 0;
        for (int i = 0; i < TOT + 3; i++) begin
            if (clr_busy) cnt++;
            step();
        end
        chk("t1_clr_len", cnt, TOT);
        rd_req = 1; rd_addr = adr(0, 0);
        step();
        rd_req = 1; rd_addr = adr(N_NUM - 1, G_NUM - 1);
        step();
        chk("t1_rd0_dout",  dout, '0);
        chk("t1_rd0_valid", 32'(dout_valid), 1);
        chk("t1_rd0_last",  32'(dout_last), 1);
        step();
        chk("t1_rd127_valid", 32'(dout_valid), 1);

        // Test 2: remapped write
        wr_en = 1; wr_addr = adr(0, 1); wr_data = 32'hA5A5_0001;
        step();
        rd_req = 1; rd_addr = adr(31, 1);
        step();
        step();
        chk("t2_remap", dout, 32'hA5A5_0001);
        rd_req = 1; rd_addr = adr(0, 1);
        step();
        step();
        chk("t2_unmapped", dout, '0);

        // Test 3: burst, with requests pulsed while busy
        for (int g = 0; g < G_NUM; g++) begin
            wr_en = 1; wr_addr = adr(2, g); wr_data = 32'h10 + 32'(g);
            step();
        end
        rd_req = 1; rd_burst = 1; rd_addr = adr(29, 3);
        step();
        nbeats = 0; nlast = 0;
        for (int i = 0; i < 7; i++) begin
            if (rd_busy) begin
                rd_req = 1; rd_addr = adr(0, 0);
            end
            step();
            if (dout_valid) begin
                if (nbeats < 8) beats[nbeats] = dout;
                if (dout_last) begin
                    nlast++;
                    chk("t3_last_beat_idx", nbeats, G_NUM - 1);
                end
                nbeats++;
            end
        end
        chk("t3_nbeats", nbeats, G_NUM);
        chk("t3_nlast", nlast, 1);
        for (int i = 0; i < G_NUM; i++) chk("t3_beat", beats[i], 32'h10 + 32'(i));

        // Test 4: same-cycle write and read of one physical word
        wr_en = 1; wr_addr = adr(5, 2); wr_data = 32'hDEAD_BEEF;
        rd_req = 1; rd_addr = adr(26, 2);
        step();
        step();
`ifdef SYN_WR_BYPASS_EN
        exp4 = 32'hDEAD_BEEF;
`else
        exp4 = 32'h0;
`endif
        chk("t4_same_cycle", dout, exp4);
        rd_req = 1; rd_addr = adr(26, 2);
        step();
        step();
        chk("t4_reread", dout, 32'hDEAD_BEEF);

        // Test 5: clear sweep after loading, write during sweep dropped
        clr_start = 1;
        step();
        cnt = 0;
        for (int i = 0; i < TOT + 3; i++) begin
            if (clr_busy) cnt++;
            if (i == 10) begin
                wr_en = 1; wr_addr = adr(0, 0); wr_data = 32'h1234_5678;
                rd_req = 1; rd_addr = adr(31, 0);
            end
            step();
        end
        chk("t5_clr_len", cnt, TOT);
        for (int k = 0; k < 3; k++) begin
            rd_req = 1; rd_burst = 1;
            rd_addr = adr((k == 0) ? 31 : (k == 1) ? 29 : 26, 0);
            step();
            for (int i = 0; i < G_NUM + 1; i++) begin
                step();
                if (dout_valid) chk("t5_zero", dout, '0);
            end
        end

        // Test 6: reset during burst beat 2
        for (int g = 0; g < G_NUM; g++) begin
            wr_en = 1; wr_addr = adr(2, g); wr_data = 32'h77 + 32'(g);
            step();
        end
        rd_req = 1; rd_burst = 1; rd_addr = adr(29, 0);
        step();
        step();
        step();
        step();
        chk("t6_beat2", dout, 32'h79);
        #2;
        rst = 0;
        #1;
        chk("t6_rst_dout",     dout, '0);
        chk("t6_rst_valid",    32'(dout_valid), 0);
        chk("t6_rst_last",     32'(dout_last), 0);
        chk("t6_rst_rd_busy",  32'(rd_busy), 0);
        chk("t6_rst_clr_busy", 32'(clr_busy), 1);
        m_reset();
        @(negedge clk);
        rst = 1;
        cnt = 0; nbeats = 0;
        for (int i = 0; i < TOT + 4; i++) begin
            if (clr_busy) cnt++;
            step();
            if (dout_valid) nbeats++;
        end
        chk("t6_clr_len", cnt, TOT);
        chk("t6_no_beats", nbeats, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 900; i++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom);
            wr_data  = $urandom;
            rd_req   = 1'($urandom_range(0, 1));
            rd_burst = ($urandom_range(0, 2) == 0);
            rd_addr  = AW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rd_addr = {N_SZ'(N_NUM - 1) - wr_addr[AW-1:G_SZ], wr_addr[G_SZ-1:0]};
            end
            clr_start = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
